// File: rtl/gc_receive_param.sv
// gc_receive_param: serial frame receiver that samples each bit a fixed delay
// after its falling edge and assembles MSB-first frames of programmable length.
module gc_receive_param #(
   parameter int SAMPLE_DELAY = 200,
   parameter int MAX_BITS     = 64,
   parameter int TIMEOUT      = 1000,
   localparam int LEN_W       = $clog2(MAX_BITS + 1)
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   input  logic                data,
   input  logic                send,
   input  logic [LEN_W-1:0]    frame_len,
   input  logic                frame_ack,
   output logic [MAX_BITS-1:0] frame,
   output logic [LEN_W-1:0]    frame_bits,
   output logic                frame_valid,
   output logic                overrun,
   output logic                timeout_err,
   output logic                busy
);
   localparam int SC_W = $clog2(SAMPLE_DELAY + 1);
   localparam int IC_W = $clog2(TIMEOUT + 1);
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BITS);

   typedef enum logic [1:0] {IDLE, WAIT_EDGE, SAMPLE} state_t;

   state_t              state_q, state_d;
   logic                d1_q, d2_q, d3_q;
   logic [SC_W-1:0]     sc_q, sc_d;
   logic [IC_W-1:0]     ic_q, ic_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d, len_q, len_d, bits_q, bits_d;
   logic [MAX_BITS-1:0] shift_q, shift_d, frame_q, frame_d;
   logic                valid_q, valid_d, overrun_q, overrun_d, timeout_q, timeout_d;

   logic                fall, sample_done, complete;
   logic [LEN_W-1:0]    eff_len;
   logic [MAX_BITS-1:0] shift_nx, mask;

   always_comb begin
      fall        = ~d2_q & d3_q;
      eff_len     = (frame_len == '0 || frame_len > MAX_L) ? MAX_L : frame_len;
      shift_nx    = (shift_q << 1) | MAX_BITS'(d3_q);
      mask        = {MAX_BITS{1'b1}} >> (MAX_L - len_q);
      sample_done = state_q == SAMPLE && sc_q == SC_W'(SAMPLE_DELAY);
      complete    = sample_done && (cnt_q + 1'b1) == len_q;
      // idle counter measures clocks since the last edge, including the sample window
      ic_d        = (fall || send || state_q == IDLE) ? '0 :
                    (ic_q == IC_W'(TIMEOUT)) ? ic_q : ic_q + 1'b1;
      state_d     = state_q;
      sc_d        = '0;
      cnt_d       = cnt_q;
      len_d       = len_q;
      shift_d     = shift_q;
      frame_d     = frame_q;
      bits_d      = bits_q;
      valid_d     = valid_q & ~frame_ack;
      overrun_d   = 1'b0;
      timeout_d   = 1'b0;
      if (send) begin
         state_d = IDLE;
         cnt_d   = '0;
         shift_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               len_d   = eff_len;
               state_d = WAIT_EDGE;
            end
            WAIT_EDGE: begin
               if (fall) begin
                  state_d = SAMPLE;
                  sc_d    = SC_W'(1);
               end else if (cnt_q != '0 && ic_q == IC_W'(TIMEOUT)) begin
                  timeout_d = 1'b1;
                  shift_d   = '0;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end
            end
            SAMPLE: begin
               sc_d = sample_done ? '0 : sc_q + 1'b1;
               if (sample_done) begin
                  state_d = WAIT_EDGE;
                  shift_d = complete ? '0 : shift_nx;
                  cnt_d   = complete ? '0 : cnt_q + 1'b1;
               end
               if (complete) begin
                  frame_d   = shift_nx & mask;
                  bits_d    = len_q;
                  valid_d   = 1'b1;
                  overrun_d = valid_q & ~frame_ack;
                  len_d     = eff_len;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state_q   <= IDLE;
         d1_q      <= 1'b1;
         d2_q      <= 1'b1;
         d3_q      <= 1'b1;
         sc_q      <= '0;
         ic_q      <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         shift_q   <= '0;
         frame_q   <= '0;
         bits_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         d1_q      <= data;
         d2_q      <= d1_q;
         d3_q      <= d2_q;
         sc_q      <= sc_d;
         ic_q      <= ic_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         shift_q   <= shift_d;
         frame_q   <= frame_d;
         bits_q    <= bits_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign frame       = frame_q;
   assign frame_bits  = bits_q;
   assign frame_valid = valid_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;
   assign busy        = state_q == SAMPLE || (state_q == WAIT_EDGE && cnt_q != '0);
endmodule

// File: tb/tb_gc_receive_param.sv
// tb_gc_receive_param: randomized frame bench against a bit-level behavioural model
// (line goes low, stays low briefly for a 1 or long for a 0, then idles high).
module tb_gc_receive_param;
   localparam int SD = 20, MB = 64, TO = 100, LW = 7, P = 40;

   logic          PCLK = 1'b0, PRESERN = 1'b0, data = 1'b1, send = 1'b1, frame_ack = 1'b0;
   logic [LW-1:0] frame_len = '0;
   logic [MB-1:0] frame;
   logic [LW-1:0] frame_bits;
   logic          frame_valid, overrun, timeout_err, busy;

   gc_receive_param #(.SAMPLE_DELAY(SD), .MAX_BITS(MB), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .data(data), .send(send), .frame_len(frame_len),
      .frame_ack(frame_ack), .frame(frame), .frame_bits(frame_bits),
      .frame_valid(frame_valid), .overrun(overrun), .timeout_err(timeout_err), .busy(busy));

   always #5 PCLK = ~PCLK;

   int errs = 0, checks = 0, cyc = 0, ovr_cnt = 0, to_cnt = 0, to_time = 0;
   logic [63:0] exp_frame = '0;
   int          exp_bits = 0, exp_ovr = 0;
   logic        exp_valid = 1'b0;

   always @(negedge PCLK) begin
      cyc++;
      if (overrun) ovr_cnt++;
      if (timeout_err) begin
         to_cnt++;
         to_time = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic drive_bit(input logic b, input logic ack);
      data = 1'b0;
      for (int m = 1; m <= P; m++) begin
         @(negedge PCLK);
         data      = (m >= (b ? 10 : 30));
         frame_ack = ack && (m == SD + 2);
      end
   endtask

   task automatic arm(input int len);
      send      = 1'b1;
      frame_len = LW'(len);
      tick(3);
      send = 1'b0;
      tick(3);
   endtask

   task automatic ack_now();
      frame_ack = 1'b1;
      tick(1);
      frame_ack = 1'b0;
      exp_valid = 1'b0;
      tick(1);
   endtask

   task automatic run_frame(input logic [63:0] v, input int len_in, input logic ack);
      int l;
      l = (len_in == 0 || len_in > MB) ? MB : len_in;
      for (int i = l - 1; i >= 0; i--) drive_bit(v[i], ack && i == 0);
      data = 1'b1;
      if (exp_valid && !ack) exp_ovr++;
      exp_valid = 1'b1;
      exp_frame = (l == 64) ? v : v & ((64'd1 << l) - 64'd1);
      exp_bits  = l;
      tick(2);
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".frame"}, frame, exp_frame);
      chk({tag, ".bits"}, 64'(frame_bits), 64'(exp_bits));
      chk({tag, ".valid"}, 64'(frame_valid), 64'(exp_valid));
      chk({tag, ".overruns"}, 64'(ovr_cnt), 64'(exp_ovr));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".frame"}, frame, 64'd0);
      chk({tag, ".bits"}, 64'(frame_bits), 64'd0);
      chk({tag, ".valid"}, 64'(frame_valid), 64'd0);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      chk({tag, ".overrun"}, 64'(overrun), 64'd0);
      chk({tag, ".timeout"}, 64'(timeout_err), 64'd0);
   endtask

   initial begin
      logic [63:0] v;
      int t5, to0, len;
      tick(3);
      check_zero("reset");
      PRESERN = 1'b1;
      tick(2);

      arm(24);
      run_frame(64'hA5C3F0, 24, 1'b0);
      check_out("len24");
      ack_now();
      chk("ack_clear", 64'(frame_valid), 64'd0);
      ack_now();
      chk("ack_idle", 64'(frame_valid), 64'd0);

      arm(0);
      run_frame(64'h0123456789ABCDEF, 0, 1'b0);
      check_out("len0_full");
      ack_now();

      arm(8);
      run_frame(64'h3C, 8, 1'b0);
      run_frame(64'h81, 8, 1'b0);
      check_out("overrun");
      run_frame(64'h3C, 8, 1'b1);
      run_frame(64'h81, 8, 1'b1);
      check_out("ack_on_complete");

      arm(16);
      v   = {$urandom, $urandom};
      to0 = to_cnt;
      t5  = 0;
      for (int i = 15; i >= 11; i--) begin
         if (i == 11) t5 = cyc;
         drive_bit(v[i], 1'b0);
      end
      data = 1'b1;
      for (int w = 0; w < TO + 80 && to_cnt == to0; w++) tick(1);
      chk("timeout.pulses", 64'(to_cnt), 64'(to0 + 1));
      chk("timeout.delay_ok", 64'((to_time - t5) >= TO && (to_time - t5) <= TO + 8), 64'd1);
      chk("timeout.busy", 64'(busy), 64'd0);
      check_out("timeout_keep");
      arm(16);
      run_frame({$urandom, $urandom}, 16, 1'b0);
      check_out("after_timeout");

      arm(64);
      to0 = to_cnt;
      v   = {$urandom, $urandom};
      for (int i = 63; i >= 54; i--) drive_bit(v[i], 1'b0);
      data = 1'b1;
      arm(64);
      chk("abort.no_timeout", 64'(to_cnt), 64'(to0));
      check_out("abort_keep");
      run_frame({$urandom, $urandom}, 64, 1'b0);
      check_out("after_abort");

      arm(64);
      v = {$urandom, $urandom};
      for (int i = 63; i >= 57; i--) drive_bit(v[i], 1'b0);
      PRESERN = 1'b0;
      #1;
      check_zero("midreset");
      tick(3);
      data      = 1'b1;
      PRESERN   = 1'b1;
      exp_valid = 1'b0;
      exp_frame = '0;
      exp_bits  = 0;
      tick(2);
      arm(64);
      run_frame({$urandom, $urandom}, 64, 1'b0);
      check_out("after_reset");

      for (int k = 0; k < 8; k++) begin
         len = int'($urandom_range(0, 127));
         if ($urandom_range(0, 1) == 1) ack_now();
         arm(len);
         run_frame({$urandom, $urandom}, len, 1'($urandom_range(0, 1)));
         check_out($sformatf("rand%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
